bbf_alu_pipe: RTL and testbench

Simulation-only, parametrised floating-point ALU for the dsptools black-box real-number model. It collapses the per-operation BBF black boxes into one opcode-driven unit with a configurable-depth pipeline, valid/ready handshakes with backpressure, saturating float-to-int conversion and optional sticky exception flags. Chisel `DspReal` ops instantiate it when a cycle-accurate latency model is needed instead of zero-delay combinational arithmetic. Data are IEEE-754 binary64 bit patterns, evaluated via Verilog `real` system functions. Not synthesisable.

---
 rtl/bbf_alu_pipe.sv | 152 +++++++++++++++
 tb/tb_bbf_alu_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bbf_alu_pipe.sv
// rtl/bbf_alu_pipe.sv - opcode-driven binary64 ALU with a LATENCY-deep stallable result pipeline
// Sticky exception flags are built only when BBF_ALU_FLAGS_EN is defined.
module bbf_alu_pipe #(
    parameter int LATENCY = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_op,
    input  logic [63:0] in1,
    input  logic [63:0] in2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic [3:0]  flags,
    input  logic        flags_clr
);
    localparam logic [3:0] OP_ADD     = 4'd0;
    localparam logic [3:0] OP_SUB     = 4'd1;
    localparam logic [3:0] OP_MUL     = 4'd2;
    localparam logic [3:0] OP_DIV     = 4'd3;
    localparam logic [3:0] OP_GT      = 4'd4;
    localparam logic [3:0] OP_GE      = 4'd5;
    localparam logic [3:0] OP_LT      = 4'd6;
    localparam logic [3:0] OP_LE      = 4'd7;
    localparam logic [3:0] OP_EQ      = 4'd8;
    localparam logic [3:0] OP_NE      = 4'd9;
    localparam logic [3:0] OP_FROMINT = 4'd10;
    localparam logic [3:0] OP_TOINT   = 4'd11;

    function automatic logic f_is_nan(input logic [63:0] x);
        return (&x[62:52]) && (|x[51:0]);
    endfunction

    logic               w_stall;
    logic               w_accept;
    logic               w_nan1;
    logic               w_nan2;
    logic               w_cmp;
    logic [63:0]        w_res;
    logic [3:0]         w_flg;
    real                w_a;
    real                w_b;
    real                w_t;
    logic [LATENCY-1:0] r_vld;
    logic [63:0]        r_dat [LATENCY];

    assign w_nan1    = f_is_nan(in1);
    assign w_nan2    = f_is_nan(in2);
    assign out_valid = r_vld[LATENCY-1];
    assign out_data  = r_dat[LATENCY-1];
    assign w_stall   = out_valid && !out_ready;
    assign in_ready  = !w_stall;
    assign w_accept  = in_valid && in_ready;

    always_comb begin
        w_a   = $bitstoreal(in1);
        w_b   = $bitstoreal(in2);
        w_t   = 0.0;
        w_cmp = 1'b0;
        w_res = 64'b0;
        w_flg = 4'b0;
        case (in_op)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                case (in_op)
                    OP_ADD:  w_res = $realtobits(w_a + w_b);
                    OP_SUB:  w_res = $realtobits(w_a - w_b);
                    OP_MUL:  w_res = $realtobits(w_a * w_b);
                    default: w_res = $realtobits(w_a / w_b);
                endcase
                w_flg[0] = w_nan1 || w_nan2 || f_is_nan(w_res);
                w_flg[1] = (in_op == OP_DIV) && (in2[62:0] == 63'b0);
            end
            OP_GT, OP_GE, OP_LT, OP_LE, OP_EQ, OP_NE: begin
                case (in_op)
                    OP_GT:   w_cmp = w_a >  w_b;
                    OP_GE:   w_cmp = w_a >= w_b;
                    OP_LT:   w_cmp = w_a <  w_b;
                    OP_LE:   w_cmp = w_a <= w_b;
                    OP_EQ:   w_cmp = w_a == w_b;
                    default: w_cmp = w_a != w_b;
                endcase
                // Unordered compares are decided from the raw bits, not the simulator.
                if (w_nan1 || w_nan2) w_cmp = (in_op == OP_NE);
                w_res    = {63'b0, w_cmp};
                w_flg[0] = w_nan1 || w_nan2;
            end
            OP_FROMINT: w_res = $realtobits(real'($signed(in1)));
            OP_TOINT: begin
                if (w_nan1) begin
                    w_flg = 4'b0101;
                end else if (w_a >= 9223372036854775808.0) begin
                    w_res    = 64'h7FFF_FFFF_FFFF_FFFF;
                    w_flg[2] = 1'b1;
                end else if (w_a < -9223372036854775808.0) begin
                    w_res    = 64'h8000_0000_0000_0000;
                    w_flg[2] = 1'b1;
                end else begin
                    w_t   = (w_a >= 0.0) ? $floor(w_a) : $ceil(w_a);
                    w_res = longint'(w_t);
                end
            end
            default: w_flg[3] = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld <= '0;
            for (int i = 0; i < LATENCY; i++) r_dat[i] <= 64'b0;
        end else if (!w_stall) begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
            r_vld[0] <= w_accept;
            r_dat[0] <= w_accept ? w_res : 64'b0;
        end
    end

`ifdef BBF_ALU_FLAGS_EN
    logic [3:0] r_flg [LATENCY];
    logic [3:0] r_flags;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) r_flg[i] <= 4'b0;
        end else if (!w_stall) begin
            for (int i = LATENCY - 1; i > 0; i--) r_flg[i] <= r_flg[i-1];
            r_flg[0] <= w_accept ? w_flg : 4'b0;
        end
    end

    // A completing result's flags win over a coincident clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_flags <= 4'b0;
        end else if (out_valid && out_ready) begin
            r_flags <= (flags_clr ? 4'b0 : r_flags) | r_flg[LATENCY-1];
        end else if (flags_clr) begin
            r_flags <= 4'b0;
        end
    end

    assign flags = r_flags;
`else
    logic w_unused_flags;
    assign w_unused_flags = ^{flags_clr, w_flg};
    assign flags = 4'b0;
`endif
endmodule

// File: tb/tb_bbf_alu_pipe.sv
// tb/tb_bbf_alu_pipe.sv - randomized scoreboard bench for bbf_alu_pipe
// Honours BBF_ALU_FLAGS_EN for the expected sticky flags.
module tb_bbf_alu_pipe;
    localparam int LAT = 3;
`ifdef BBF_ALU_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    typedef struct packed {
        logic [63:0] d;
        logic [3:0]  f;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [63:0] in1;
    logic [63:0] in2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [3:0]  flags;
    logic        flags_clr;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        q[$];
    logic [3:0]  exp_flags = 4'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = 64'b0;
    logic        ov_en = 1'b0;
    exp_t        ov_exp;
    logic        s_vld, s_acc, s_irdy;

    always #5 clock = ~clock;

    bbf_alu_pipe #(.LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in1(in1), .in2(in2), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .flags(flags), .flags_clr(flags_clr)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit is_nan(input logic [63:0] x);
        return (x[62:52] == 11'h7FF) && (x[51:0] != 52'b0);
    endfunction

    // Reference: straight from the opcode table with plain real arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
        exp_t   e;
        real    ra, rb;
        bit     na, nb, c;
        longint t;
        ra = $bitstoreal(a);
        rb = $bitstoreal(b);
        na = is_nan(a);
        nb = is_nan(b);
        e  = '0;
        if (op <= 4'd3) begin
            if (op == 4'd0) e.d = $realtobits(ra + rb);
            else if (op == 4'd1) e.d = $realtobits(ra - rb);
            else if (op == 4'd2) e.d = $realtobits(ra * rb);
            else e.d = $realtobits(ra / rb);
            e.f[0] = na || nb || is_nan(e.d);
            e.f[1] = (op == 4'd3) && (rb == 0.0);
        end else if (op <= 4'd9) begin
            if (na || nb) c = (op == 4'd9);
            else case (op)
                4'd4: c = ra > rb;
                4'd5: c = ra >= rb;
                4'd6: c = ra < rb;
                4'd7: c = ra <= rb;
                4'd8: c = ra == rb;
                default: c = ra != rb;
            endcase
            e.d    = {63'b0, c};
            e.f[0] = na || nb;
        end else if (op == 4'd10) begin
            t   = a;
            e.d = $realtobits(real'(t));
        end else if (op == 4'd11) begin
            if (na) begin
                e.f = 4'b0101;
            end else if (ra >= 2.0 ** 63) begin
                e.d = 64'h7FFF_FFFF_FFFF_FFFF; e.f = 4'b0100;
            end else if (ra < -(2.0 ** 63)) begin
                e.d = 64'h8000_0000_0000_0000; e.f = 4'b0100;
            end else begin
                t = longint'(ra);
                if (ra >= 0.0 && real'(t) > ra) t = t - 1;
                if (ra < 0.0 && real'(t) < ra) t = t + 1;
                e.d = t;
            end
        end else begin
            e.f = 4'b1000;
        end
        return e;
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return {$urandom, $urandom};
            1: return $realtobits(real'($urandom_range(0, 2000)) - 1000.0);
            2: return 64'h7FF8_0000_0000_0000;
            3: return $urandom_range(0, 1) ? 64'h7FF0_0000_0000_0000 : 64'hFFF0_0000_0000_0000;
            4: return $urandom_range(0, 1) ? 64'h0 : 64'h8000_0000_0000_0000;
            5: return $realtobits(($urandom_range(0, 1) ? 1.0 : -1.0) * (9.0e18 + real'($urandom_range(0, 8)) * 1.0e17));
            6: return $realtobits((real'($urandom_range(0, 400)) - 200.0) / 8.0);
            default: return $urandom_range(0, 1) ? 64'h43E0_0000_0000_0000 : 64'hC3E0_0000_0000_0000;
        endcase
    endfunction

    task automatic step(input logic v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic ordy, input logic clr,
                        output logic o_vld, output logic o_acc, output logic o_irdy);
        exp_t       e;
        logic [3:0] nf;
        @(negedge clock);
        in_valid = v; in_op = op; in1 = a; in2 = b; out_ready = ordy; flags_clr = clr;
        #1;
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, prev_data);
        end
        check("in_ready", in_ready, !(out_valid && !ordy));
        check("flags", flags, exp_flags);
        o_vld  = out_valid;
        o_irdy = in_ready;
        o_acc  = v && in_ready;
        nf = clr ? 4'b0 : exp_flags;
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                check("spurious_output", 1, 0);
            end else begin
                e = q.pop_front();
                check("data", out_data, e.d);
                if (FLAGS_EN) nf = nf | e.f;
            end
        end
        if (o_acc) q.push_back(ov_en ? ov_exp : model(op, a, b));
        prev_stall = out_valid && !ordy;
        prev_data  = out_data;
        @(posedge clock);
        exp_flags = FLAGS_EN ? nf : 4'b0;
    endtask

    task automatic run_one(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] xd, input logic [3:0] xf);
        logic vld, acc, ir;
        ov_en = 1'b1; ov_exp.d = xd; ov_exp.f = xf;
        step(1, op, a, b, 1, 0, vld, acc, ir);
        ov_en = 1'b0;
        check("accept", acc, 1);
        for (int k = 1; k <= LAT; k++) begin
            step(0, 0, 0, 0, 1, 0, vld, acc, ir);
            if (k < LAT) check("lat_early", vld, 0);
            else check("lat_hit", vld, 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; in_valid = 1'b0; flags_clr = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        q.delete();
        exp_flags  = 4'b0;
        prev_stall = 1'b0;
    endtask

    initial begin
        int sent;
        logic ordy;
        reset = 1'b1; in_valid = 1'b0; in_op = 4'd0; in1 = 64'b0; in2 = 64'b0;
        out_ready = 1'b1; flags_clr = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_flags", flags, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b0;

        run_one(4'd0, 64'h3FF8_0000_0000_0000, 64'h4002_0000_0000_0000, 64'h400E_0000_0000_0000, 4'b0000);
        run_one(4'd3, 64'h3FF0_0000_0000_0000, 64'h0, 64'h7FF0_0000_0000_0000, 4'b0010);
        step(0, 0, 0, 0, 1, 0, s_vld, s_acc, s_irdy);
        step(0, 0, 0, 0, 1, 1, s_vld, s_acc, s_irdy);
        step(0, 0, 0, 0, 1, 0, s_vld, s_acc, s_irdy);
        run_one(4'd11, 64'h4415_AF1D_78B5_8C40, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0100);
        run_one(4'd11, 64'hC004_0000_0000_0000, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0000);
        run_one(4'd6, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h1, 4'b0000);
        run_one(4'd8, 64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h0, 4'b0001);
        run_one(4'd9, 64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h1, 4'b0001);
        run_one(4'd13, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h0, 4'b1000);
        step(0, 0, 0, 0, 1, 1, s_vld, s_acc, s_irdy);

        sent = 0;
        for (int c = 0; c < 40 && (sent < 8 || q.size() > 0); c++) begin
            ordy = !(c >= LAT && c < LAT + 5);
            step(sent < 8, 4'd0, rnd_operand(), rnd_operand(), ordy, 0, s_vld, s_acc, s_irdy);
            if (!ordy) check("stall_in_ready", s_irdy, 0);
            if (c == LAT) check("stall_first_valid", s_vld, 1);
            if (s_acc) sent++;
        end
        check("stall_all_sent", sent, 8);
        check("stall_drained", q.size(), 0);

        for (int c = 0; c < 400; c++) begin
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), rnd_operand(), rnd_operand(),
                 $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, s_vld, s_acc, s_irdy);
        end
        for (int c = 0; c < 60 && q.size() > 0; c++) step(0, 0, 0, 0, 1, 0, s_vld, s_acc, s_irdy);
        check("random_drained", q.size(), 0);

        for (int c = 0; c < 3; c++) begin
            step(1, 4'd2, rnd_operand(), rnd_operand(), 1, 0, s_vld, s_acc, s_irdy);
            check("inflight_accept", s_acc, 1);
        end
        do_reset();
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 0, 0, 1, 0, s_vld, s_acc, s_irdy);
            check("post_reset_quiet", s_vld, 0);
        end
        run_one(4'd1, 64'h4014_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h4010_0000_0000_0000, 4'b0000);
        step(0, 0, 0, 0, 1, 0, s_vld, s_acc, s_irdy);
        check("final_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
